compare_result_tx: RTL and testbench
====================================

Name: compare_result_tx

Overview:
- UART transmitter at the output end of the correlation compare path.
- Waits for the rising edge of transmit_ready from the compare stage, then latches resultCompare and finalIndex.
- Sends the latched values to the host MCU as a fixed-format 8N1 serial packet.
- Runs on the FPGA system clock; no handshake back to the compare stage other than overrun reporting.

Parameters:
- CLKS_PER_BIT, 347, clk cycles per UART bit (40 MHz / 115200); legal range ≥ 2.
- INDEX_W, 12, width of final_index; legal range 9..16.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- transmit_ready  input  1  level from compare stage; rising edge starts a packet.
- result_compare  input  1  compare outcome, sampled at trigger.
- final_index  input  INDEX_W  peak index, sampled at trigger.
- tx  output  1  UART line; idle high.
- busy  output  1  high while a packet is on the line.
- done  output  1  one-cycle pulse at packet end.
- overrun  output  1  sticky; a trigger arrived while busy.

Behaviour:
- Reset values: tx=1, busy=0, done=0, overrun=0, state=IDLE, all counters 0.
- Edge-detect register (prev_ready) resets to 1, so transmit_ready already high at reset release does not trigger. A 0 must be seen first.
- Trigger: transmit_ready=1 at clk edge N and prev_ready=0.
  - At edge N, latch result_compare and final_index.
  - tx=0 (start bit) and busy=1 from edge N+1.
- Packet format, bytes in order:
  - B0 = 0xA5
  - B1 = {7'b0, result}
  - B2 = zero-extended index[INDEX_W-1:8]
  - B3 = index[7:0]
- Each byte is sent as: start bit 0, 8 data bits LSB first, stop bit 1. Each bit holds exactly CLKS_PER_BIT cycles.
- No idle gap between bytes: the stop bit is followed directly by the next start bit.
- Packet length = 40*CLKS_PER_BIT cycles.
- Counters:
  - baud 0..CLKS_PER_BIT-1
  - bit 0..7
  - byte 0..NBYTES-1
- FSM: IDLE -> START -> DATA (8 bits) -> STOP.
  - STOP -> START if more bytes remain.
  - STOP -> IDLE after the last byte.
- End of packet, on the cycle after the last stop bit completes:
  - busy=0 and done=1 for exactly one cycle.
  - tx stays 1.
- Trigger while busy (edge detected during START/DATA/STOP): ignored, not queued. overrun=1 until reset. The current packet is unaffected.
- Trigger on the same cycle done pulses: busy is already 0 there, so it is accepted. The start bit appears on the next cycle with no overrun.
- Input changes after the latch never affect the packet in flight.
- Reset mid-packet: tx=1 and busy=0 from the next edge. No done pulse. The partial packet is abandoned and overrun is cleared.

Optional Feature:
- Macro: COMPARE_TX_CHECKSUM_EN
- Defined:
  - Fifth byte B4 = B0^B1^B2^B3 is sent after B3.
  - NBYTES=5; packet length 50*CLKS_PER_BIT cycles.
  - done pulses after B4's stop bit.
- Undefined:
  - NBYTES=4; no checksum logic is synthesised.

Test Plan (CLKS_PER_BIT=4, INDEX_W=12):
1. Hold transmit_ready=1 through reset and release, run 200 cycles -> tx=1, busy=0, done never asserted.
2. transmit_ready 0->1 with result=1, index=0x3C7:
   - tx low starts 1 cycle after the edge.
   - Decoded bytes are A5,01,03,C7.
   - busy is high for 160 cycles, then done pulses once.
3. During test 2, at cycle 50, drive result=0, index=0xFFF and pulse transmit_ready 0->1 ->
   - Bytes are still A5,01,03,C7.
   - overrun=1 and remains 1 after done.
4. Retrigger on the done cycle with result=0, index=0x800 ->
   - Bytes A5,00,08,00.
   - No gap beyond one cycle; overrun unchanged.
5. Assert reset during the DATA bits of B2 -> next cycle tx=1, busy=0, overrun=0, and no done pulse.
6. With COMPARE_TX_CHECKSUM_EN, result=1, index=0x3C7 ->
   - Bytes A5,01,03,C7,60.
   - busy is high for 200 cycles, then done pulses.

Source files
------------

// File: rtl/compare_result_tx.sv
// compare_result_tx: sends {A5, result, index hi, index lo} as 8N1 UART bytes.
// Define COMPARE_TX_CHECKSUM_EN to append an XOR checksum byte after index lo.
module compare_result_tx #(
  parameter int CLKS_PER_BIT = 347,
  parameter int INDEX_W      = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               transmit_ready,
  input  logic               result_compare,
  input  logic [INDEX_W-1:0] final_index,
  output logic               tx,
  output logic               busy,
  output logic               done,
  output logic               overrun
);

`ifdef COMPARE_TX_CHECKSUM_EN
  localparam logic [2:0] LAST_BYTE = 3'd4;
`else
  localparam logic [2:0] LAST_BYTE = 3'd3;
`endif

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic [2:0]          byte_q, byte_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                overrun_q, overrun_d;
  logic                prev_ready_q, prev_ready_d;
  logic                result_q, result_d;
  logic [INDEX_W-1:0]  index_q, index_d;

  logic [15:0] idx_ext;
  logic [7:0]  b1, b2, b3;
  logic [7:0]  cur_byte;
  logic        trig;
  logic        bit_end;

  always_comb begin
    idx_ext = 16'(index_q);
    b1      = {7'b0, result_q};
    b2      = idx_ext[15:8];
    b3      = idx_ext[7:0];
    case (byte_q)
      3'd1:    cur_byte = b1;
      3'd2:    cur_byte = b2;
      3'd3:    cur_byte = b3;
`ifdef COMPARE_TX_CHECKSUM_EN
      3'd4:    cur_byte = 8'hA5 ^ b1 ^ b2 ^ b3;
`endif
      default: cur_byte = 8'hA5;
    endcase
  end

  always_comb begin
    trig         = transmit_ready & ~prev_ready_q;
    bit_end      = (baud_q == BAUD_LAST);
    state_d      = state_q;
    baud_d       = baud_q;
    bit_d        = bit_q;
    byte_d       = byte_q;
    tx_d         = tx_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    overrun_d    = overrun_q;
    prev_ready_d = transmit_ready;
    result_d     = result_q;
    index_d      = index_q;

    if (state_q != IDLE) begin
      baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (trig) begin
          result_d = result_compare;
          index_d  = final_index;
          state_d  = START;
          tx_d     = 1'b0;
          busy_d   = 1'b1;
          baud_d   = '0;
          bit_d    = '0;
          byte_d   = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = cur_byte[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = cur_byte[bit_d];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (byte_q == LAST_BYTE) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            byte_d  = '0;
          end else begin
            // next start bit follows the stop bit with no idle gap
            state_d = START;
            byte_d  = byte_q + 3'd1;
            tx_d    = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (trig && state_q != IDLE) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      baud_q       <= '0;
      bit_q        <= '0;
      byte_q       <= '0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
      // held high so a level already present at release is not an edge
      prev_ready_q <= 1'b1;
      result_q     <= 1'b0;
      index_q      <= '0;
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      byte_q       <= byte_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      overrun_q    <= overrun_d;
      prev_ready_q <= prev_ready_d;
      result_q     <= result_d;
      index_q      <= index_d;
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_compare_result_tx.sv
// tb_compare_result_tx: directed bench for the compare result UART sender.
// Records tx/busy/done each cycle, then decodes and checks each packet.
module tb_compare_result_tx;

  localparam int CPB = 4;
  localparam int IW  = 12;
`ifdef COMPARE_TX_CHECKSUM_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif
  localparam int PKT = NB * 10 * CPB;

  logic          clk = 1'b0;
  logic          reset;
  logic          transmit_ready;
  logic          result_compare;
  logic [IW-1:0] final_index;
  logic          tx, busy, done, overrun;

  compare_result_tx #(
    .CLKS_PER_BIT(CPB),
    .INDEX_W     (IW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .transmit_ready(transmit_ready),
    .result_compare(result_compare),
    .final_index   (final_index),
    .tx            (tx),
    .busy          (busy),
    .done          (done),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   n = 0;
  logic tx_l   [0:4095];
  logic busy_l [0:4095];
  logic done_l [0:4095];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    tx_l[n]   = tx;
    busy_l[n] = busy;
    done_l[n] = done;
    n++;
  endtask

  task automatic idle_run(input string tag, input int cycles);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    chk(tag, 32'(bad), 32'd0);
  endtask

  // exp holds B0..B4 from the top byte down
  task automatic check_packet(input string tag, input int s,
                              input logic [39:0] exp);
    int wave_bad;
    int busy_bad;
    int done_bad;
    wave_bad = 0;
    busy_bad = 0;
    done_bad = 0;
    for (int k = 0; k < NB; k++) begin
      logic [7:0] got;
      int base;
      base = s + k * 10 * CPB;
      for (int b = 0; b < 8; b++)
        got[b] = tx_l[base + (b + 1) * CPB + CPB / 2];
      chk($sformatf("%s_byte%0d", tag, k), 32'(got),
          32'(exp[39 - 8 * k -: 8]));
    end
    for (int i = 0; i < PKT; i++) begin
      int bp;
      int pos;
      logic [7:0] eb;
      logic ebit;
      bp  = i / CPB;
      pos = bp % 10;
      eb  = exp[39 - 8 * (bp / 10) -: 8];
      if (pos == 0) ebit = 1'b0;
      else if (pos == 9) ebit = 1'b1;
      else ebit = eb[pos - 1];
      if (tx_l[s + i] !== ebit) wave_bad++;
      if (busy_l[s + i] !== 1'b1) busy_bad++;
      if (done_l[s + i] !== 1'b0) done_bad++;
    end
    chk({tag, "_wave"}, 32'(wave_bad), 32'd0);
    chk({tag, "_busy_len"}, 32'(busy_bad), 32'd0);
    chk({tag, "_done_early"}, 32'(done_bad), 32'd0);
    chk({tag, "_end_busy"}, 32'(busy_l[s + PKT]), 32'd0);
    chk({tag, "_end_done"}, 32'(done_l[s + PKT]), 32'd1);
    chk({tag, "_end_tx"}, 32'(tx_l[s + PKT]), 32'd1);
    chk({tag, "_done_once"}, 32'(done_l[s + PKT + 1]), 32'd0);
  endtask

  initial begin
    int s0, s1, s2;
    reset          = 1'b1;
    transmit_ready = 1'b1;
    result_compare = 1'b0;
    final_index    = '0;

    step();
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    step();
    reset = 1'b0;
    idle_run("ready_high_at_release", 200);

    // packet 1
    transmit_ready = 1'b0;
    step();
    chk("pre_trig_tx", 32'(tx), 32'd1);
    result_compare = 1'b1;
    final_index    = 12'h3C7;
    transmit_ready = 1'b1;
    s0 = n;
    step();
    chk("p1_start_latency", 32'(tx), 32'd0);
    chk("p1_busy_rise", 32'(busy), 32'd1);
    repeat (49) step();

    // overlapping trigger with new data
    transmit_ready = 1'b0;
    step();
    result_compare = 1'b0;
    final_index    = 12'hFFF;
    transmit_ready = 1'b1;
    step();
    chk("overrun_set", 32'(overrun), 32'd1);
    transmit_ready = 1'b0;
    while (n < s0 + PKT + 1) step();
    chk("done_seen_for_retrig", 32'(done), 32'd1);
    chk("overrun_after_done", 32'(overrun), 32'd1);

    // retrigger on the done cycle
    result_compare = 1'b0;
    final_index    = 12'h800;
    transmit_ready = 1'b1;
    s1 = n;
    step();
    chk("retrig_gap", 32'(s1 - s0), 32'(PKT + 1));
    chk("retrig_start", 32'(tx), 32'd0);
    while (n < s1 + PKT + 2) step();
    check_packet("p1", s0, {8'hA5, 8'h01, 8'h03, 8'hC7, 8'h60});
    check_packet("p2", s1, {8'hA5, 8'h00, 8'h08, 8'h00, 8'hAD});
    chk("overrun_kept", 32'(overrun), 32'd1);

    // packet 3, reset during a zero data bit of B2
    transmit_ready = 1'b0;
    step();
    result_compare = 1'b1;
    final_index    = 12'h3C7;
    transmit_ready = 1'b1;
    s2 = n;
    step();
    while (n < s2 + 94) step();
    chk("pre_rst_tx", 32'(tx), 32'd0);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_overrun", 32'(overrun), 32'd1);
    reset = 1'b1;
    step();
    chk("mid_rst_tx", 32'(tx), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_overrun", 32'(overrun), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    idle_run("after_mid_rst", 200);
    chk("after_mid_rst_overrun", 32'(overrun), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
